reg_read_bypass_stage: RTL and testbench
========================================

Name: reg_read_bypass_stage

Overview:
Parametrised register-read stage that succeeds the fixed int/fp read stage. It reads NUM_SRC source operands from the unified int/fp register files and forwards results from NUM_BYP later-stage bypass ports. Operands whose producer is still in flight are captured by snooping the bypass ports while the instruction is held. It sits between decode and execute and uses a valid/ready handshake on both sides plus a flush.

Parameters:
XLEN, 32, operand data width (int and fp share width)
NUM_SRC, 3, source operands per instruction (rs1/rs2/rs3)
NUM_BYP, 2, bypass ports; port 0 = youngest producer, highest priority
REG_ADDR_W, 5, register address width
PAYLOAD_W, 96, opaque pass-through bundle (op, pc, insn, csrAddr, trapInfo)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  pipeline flush from controller
in_valid  in  1  decode has an instruction
in_ready  out  1  stage accepts this cycle
in_payload  in  PAYLOAD_W  pass-through bundle
in_src_en  in  NUM_SRC  operand i used
in_src_is_fp  in  NUM_SRC  operand i is an fp register
in_src_addr  in  NUM_SRC*REG_ADDR_W  operand addresses
in_src_busy  in  NUM_SRC  scoreboard: producer of operand i not yet written back
rf_read_addr  out  NUM_SRC*REG_ADDR_W  combinational copy of in_src_addr
rf_read_is_fp  out  NUM_SRC  combinational copy of in_src_is_fp
rf_read_data  in  NUM_SRC*XLEN  same-cycle register file data
byp_valid  in  NUM_BYP  bypass port carries a result
byp_is_fp  in  NUM_BYP  result class
byp_addr  in  NUM_BYP*REG_ADDR_W  destination register
byp_data  in  NUM_BYP*XLEN  result value
out_valid  out  1  instruction with all operands ready
out_ready  in  1  execute accepts
out_payload  out  PAYLOAD_W  registered bundle
out_src_value  out  NUM_SRC*XLEN  registered operand values

Behaviour:
- State: valid_q, payload_q, per-operand value_q[i] and rdy_q[i]. All are cleared on rst or flush. Out_valid, out_payload and out_src_value reset to 0.
- in_ready = !flush && (!valid_q || (out_valid && out_ready)). Accept = in_valid && in_ready. Drain and accept in the same cycle are allowed, giving 1 instruction/cycle with 1-cycle latency.
- Per-operand resolution at accept, in priority order:
  - !src_en → value 0, rdy 1.
  - Int address 0 → value 0, rdy 1; never bypassed.
  - Lowest-index bypass port with valid, matching addr and matching is_fp → byp_data, rdy 1. This applies even if busy is set.
  - src_busy → value 0, rdy 0.
  - Otherwise → rf_read_data, rdy 1.
- Held with rdy_q[i]=0: each cycle, the lowest-index matching bypass hit (same match rule, using the stored addr/class) loads value_q[i] and sets rdy_q[i]. Operands with rdy_q=1 are never overwritten.
- out_valid = valid_q && &rdy_q. A wake-up in cycle N gives out_valid in cycle N+1.
- Accept without drain is impossible by construction; drain without accept clears valid_q.
- flush takes priority over accept, drain and wake-up. The incoming instruction is dropped, and in_ready is forced low that cycle.
- rst mid-operation behaves identically to flush.
- An operand whose producer never arrives stalls indefinitely. This is legal; only flush recovers it.

Decomposition:
- Package RegReadTypes: typedefs src_vec_t and byp_port_t (valid, is_fp, addr, data); constant ZERO_REG=0.
- Sub-module reg_read_operand_sel, instantiated NUM_SRC times. It contains the combinational match/priority select for one operand, shared by accept-time and held-time resolution.
- Top level holds the registers and handshake.

Test Plan:
- No hazard, rf_read_data={0x11,0x22,0x33}, out_ready=1, back-to-back inputs → out_valid one cycle later with those values, 1/cycle throughput.
- Int x5 busy, fp f5 on byp0 with 0xAAAA → no match (class differs). Int x5 on byp1 two cycles later with 0xBEEF → value 0xBEEF, out_valid the next cycle. in_ready is low while held.
- Same addr x7 on byp0=0x1 and byp1=0x2 at accept → value 0x1. Int x0 with byp addr 0 valid → value 0.
- Output held with out_ready=0 for 3 cycles, rdy already set, byp matching with a new value → value unchanged, in_ready low until drain.
- Held with rdy=0 plus flush in the same cycle as a bypass hit → valid cleared, next in_valid accepted one cycle later, no stale output.
- rst asserted while held → all outputs 0 the next cycle; bench checks in_ready=1 after rst drops.

Source files
------------

// File: rtl/reg_read_bypass_stage_pkg.sv
// reg_read_types: shared defaults, operand vector and bypass port types, hardwired-zero register index
package reg_read_types;
  localparam int DEF_XLEN = 32;
  localparam int DEF_NUM_SRC = 3;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG = 0;
  typedef logic [DEF_NUM_SRC-1:0] src_vec_t;
  typedef struct packed {
    logic                      valid;
    logic                      is_fp;
    logic [DEF_REG_ADDR_W-1:0] addr;
    logic [DEF_XLEN-1:0]       data;
  } byp_port_t;
endpackage

// File: rtl/reg_read_bypass_stage_operand_sel.sv
// reg_read_operand_sel: one operand's bypass match (lowest port wins, int x0 never matches) and accept-time value/ready resolve
module reg_read_operand_sel
  import reg_read_types::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_BYP    = 2,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                       en,
  input  logic                       is_fp,
  input  logic [REG_ADDR_W-1:0]      addr,
  input  logic                       busy,
  input  logic [XLEN-1:0]            rf_data,
  input  logic [NUM_BYP-1:0]         byp_valid,
  input  logic [NUM_BYP-1:0]         byp_is_fp,
  input  logic [NUM_BYP*REG_ADDR_W-1:0] byp_addr,
  input  logic [NUM_BYP*XLEN-1:0]    byp_data,
  output logic                       hit,
  output logic [XLEN-1:0]            hit_data,
  output logic [XLEN-1:0]            value,
  output logic                       rdy
);
  logic zero;
  assign zero = !is_fp && addr == REG_ADDR_W'(ZERO_REG);
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int b = NUM_BYP - 1; b >= 0; b--)
      if (!zero && byp_valid[b] && byp_is_fp[b] == is_fp && byp_addr[b*REG_ADDR_W +: REG_ADDR_W] == addr) begin
        hit = 1'b1;
        hit_data = byp_data[b*XLEN +: XLEN];
      end
    value = (!en || zero) ? '0 : hit ? hit_data : busy ? '0 : rf_data;
    rdy = !en || zero || hit || !busy;
  end
endmodule

// File: rtl/reg_read_bypass_stage.sv
// reg_read_bypass_stage: reads rf operands + bypass, holds and snoops bypass for busy operands; valid/ready in/out, flush
module reg_read_bypass_stage
  import reg_read_types::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int NUM_BYP    = 2,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int PAYLOAD_W  = 96
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic [NUM_SRC-1:0]            in_src_en,
  input  logic [NUM_SRC-1:0]            in_src_is_fp,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] in_src_addr,
  input  logic [NUM_SRC-1:0]            in_src_busy,
  output logic [NUM_SRC*REG_ADDR_W-1:0] rf_read_addr,
  output logic [NUM_SRC-1:0]            rf_read_is_fp,
  input  logic [NUM_SRC*XLEN-1:0]       rf_read_data,
  input  logic [NUM_BYP-1:0]            byp_valid,
  input  logic [NUM_BYP-1:0]            byp_is_fp,
  input  logic [NUM_BYP*REG_ADDR_W-1:0] byp_addr,
  input  logic [NUM_BYP*XLEN-1:0]       byp_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PAYLOAD_W-1:0]          out_payload,
  output logic [NUM_SRC*XLEN-1:0]       out_src_value
);
  logic valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [NUM_SRC*XLEN-1:0] value_q, value_d, hit_data, sel_value;
  logic [NUM_SRC*REG_ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_SRC-1:0] rdy_q, rdy_d, fp_q, fp_d, held, hit, sel_rdy;
  logic accept, drain;
  assign out_valid = valid_q && &rdy_q;
  assign drain = out_valid && out_ready;
  assign in_ready = !flush && (!valid_q || drain);
  assign accept = in_valid && in_ready;
  assign out_payload = payload_q;
  assign out_src_value = value_q;
  assign rf_read_addr = in_src_addr;
  assign rf_read_is_fp = in_src_is_fp;
  assign held = {NUM_SRC{valid_q}} & ~rdy_q;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_sel
    reg_read_operand_sel #(.XLEN(XLEN), .NUM_BYP(NUM_BYP), .REG_ADDR_W(REG_ADDR_W)) u_sel (
      .en       (in_src_en[s]),
      .is_fp    (held[s] ? fp_q[s] : in_src_is_fp[s]),
      .addr     (held[s] ? addr_q[s*REG_ADDR_W +: REG_ADDR_W] : in_src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
      .busy     (in_src_busy[s]),
      .rf_data  (rf_read_data[s*XLEN +: XLEN]),
      .byp_valid(byp_valid),
      .byp_is_fp(byp_is_fp),
      .byp_addr (byp_addr),
      .byp_data (byp_data),
      .hit      (hit[s]),
      .hit_data (hit_data[s*XLEN +: XLEN]),
      .value    (sel_value[s*XLEN +: XLEN]),
      .rdy      (sel_rdy[s])
    );
  end
  always_comb begin
    valid_d = valid_q;
    payload_d = payload_q;
    value_d = value_q;
    rdy_d = rdy_q;
    addr_d = addr_q;
    fp_d = fp_q;
    if (flush) begin
      valid_d = 1'b0;
      payload_d = '0;
      value_d = '0;
      rdy_d = '0;
      addr_d = '0;
      fp_d = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      payload_d = in_payload;
      value_d = sel_value;
      rdy_d = sel_rdy;
      addr_d = in_src_addr;
      fp_d = in_src_is_fp;
    end else begin
      valid_d = valid_q && !drain;
      for (int i = 0; i < NUM_SRC; i++)
        if (held[i] && hit[i]) begin
          value_d[i*XLEN +: XLEN] = hit_data[i*XLEN +: XLEN];
          rdy_d[i] = 1'b1;
        end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      valid_q <= 1'b0;
      payload_q <= '0;
      value_q <= '0;
      rdy_q <= '0;
      addr_q <= '0;
      fp_q <= '0;
    end else begin
      valid_q <= valid_d;
      payload_q <= payload_d;
      value_q <= value_d;
      rdy_q <= rdy_d;
      addr_q <= addr_d;
      fp_q <= fp_d;
    end
endmodule

// File: tb/tb_reg_read_bypass_stage.sv
// tb_reg_read_bypass_stage: directed scenarios with hand-computed expectations for the register-read bypass stage
module tb_reg_read_bypass_stage;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [95:0] in_payload = '0;
  logic [2:0] in_src_en = '0, in_src_is_fp = '0, in_src_busy = '0;
  logic [14:0] in_src_addr = '0, rf_read_addr;
  logic [2:0] rf_read_is_fp;
  logic [95:0] rf_read_data = '0;
  logic [1:0] byp_valid = '0, byp_is_fp = '0;
  logic [9:0] byp_addr = '0;
  logic [63:0] byp_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [95:0] out_payload, out_src_value;
  logic [31:0] ov0, ov1, ov2;
  int vecs = 0, errs = 0;
  assign ov0 = out_src_value[31:0];
  assign ov1 = out_src_value[63:32];
  assign ov2 = out_src_value[95:64];
  always #5 clk = ~clk;
  reg_read_bypass_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_src_en(in_src_en), .in_src_is_fp(in_src_is_fp), .in_src_addr(in_src_addr), .in_src_busy(in_src_busy),
    .rf_read_addr(rf_read_addr), .rf_read_is_fp(rf_read_is_fp), .rf_read_data(rf_read_data),
    .byp_valid(byp_valid), .byp_is_fp(byp_is_fp), .byp_addr(byp_addr), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload), .out_src_value(out_src_value)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [95:0] p, input logic [2:0] en, input logic [2:0] fp, input logic [2:0] busy,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v;
    in_payload = p;
    in_src_en = en;
    in_src_is_fp = fp;
    in_src_busy = busy;
    in_src_addr = {a2, a1, a0};
    rf_read_data = {d2, d1, d0};
  endtask
  task automatic set_byp(input int p, input logic v, input logic fp, input logic [4:0] a, input logic [31:0] d);
    byp_valid[p] = v;
    byp_is_fp[p] = fp;
    byp_addr[p*5 +: 5] = a;
    byp_data[p*32 +: 32] = d;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (out_payload !== 96'h0) begin errs++; $display("FAIL reset_payload got %h want 0", out_payload); end
    vecs++; if (out_src_value !== 96'h0) begin errs++; $display("FAIL reset_values got %h want 0", out_src_value); end
    rst = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_no_hazard;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k > 0) begin
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL nohaz_valid[%0d] got %b want 1", k, out_valid); end
        vecs++; if (out_payload !== 96'(100 + k - 1)) begin errs++; $display("FAIL nohaz_payload[%0d] got %h want %h", k, out_payload, 96'(100 + k - 1)); end
        vecs++; if ({ov2, ov1, ov0} !== {32'(32'h33 + k - 1), 32'(32'h22 + k - 1), 32'(32'h11 + k - 1)})
          begin errs++; $display("FAIL nohaz_values[%0d] got %h %h %h want %h %h %h", k, ov0, ov1, ov2, 32'h11 + k - 1, 32'h22 + k - 1, 32'h33 + k - 1); end
      end
      if (k < 3) begin
        drive(1'b1, 96'(100 + k), 3'b111, 3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 32'(32'h11 + k), 32'(32'h22 + k), 32'(32'h33 + k));
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL nohaz_in_ready[%0d] got %b want 1", k, in_ready); end
        if (k == 0) begin
          vecs++; if (rf_read_addr !== {5'd3, 5'd2, 5'd1}) begin errs++; $display("FAIL rf_read_addr got %h want %h", rf_read_addr, {5'd3, 5'd2, 5'd1}); end
        end
      end else drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    end
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL nohaz_drained got %b want 0", out_valid); end
  endtask
  task automatic test_bypass_wakeup;
    drive(1'b1, 96'h200, 3'b001, 3'b000, 3'b001, 5'd5, 5'd0, 5'd0, 32'h5555, 32'h66, 32'h77);
    set_byp(0, 1'b1, 1'b1, 5'd5, 32'hAAAA);
    tick;
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL wake_held_valid0 got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL wake_held_in_ready0 got %b want 0", in_ready); end
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL wake_fp_no_match got %b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL wake_held_in_ready1 got %b want 0", in_ready); end
    set_byp(0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_byp(1, 1'b1, 1'b0, 5'd5, 32'hBEEF);
    tick;
    set_byp(1, 1'b0, 1'b0, 5'd0, 32'h0);
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL wake_valid got %b want 1", out_valid); end
    vecs++; if ({ov2, ov1, ov0} !== {32'h0, 32'h0, 32'hBEEF}) begin errs++; $display("FAIL wake_values got %h %h %h want beef 0 0", ov0, ov1, ov2); end
    vecs++; if (out_payload !== 96'h200) begin errs++; $display("FAIL wake_payload got %h want 200", out_payload); end
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL wake_drained got %b want 0", out_valid); end
  endtask
  task automatic test_priority;
    drive(1'b1, 96'h300, 3'b111, 3'b000, 3'b001, 5'd7, 5'd0, 5'd9, 32'h777, 32'h99, 32'h33);
    set_byp(0, 1'b1, 1'b0, 5'd7, 32'h1);
    set_byp(1, 1'b1, 1'b0, 5'd7, 32'h2);
    tick;
    vecs++; if ({ov2, ov1, ov0} !== {32'h33, 32'h0, 32'h1}) begin errs++; $display("FAIL prio_values got %h %h %h want 1 0 33", ov0, ov1, ov2); end
    drive(1'b1, 96'h301, 3'b011, 3'b010, 3'b000, 5'd0, 5'd0, 5'd4, 32'h99, 32'h44, 32'h12);
    set_byp(0, 1'b1, 1'b0, 5'd0, 32'h55);
    set_byp(1, 1'b1, 1'b1, 5'd0, 32'h66);
    tick;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL zero_valid got %b want 1", out_valid); end
    vecs++; if ({ov2, ov1, ov0} !== {32'h0, 32'h66, 32'h0}) begin errs++; $display("FAIL zero_values got %h %h %h want 0 66 0", ov0, ov1, ov2); end
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    set_byp(0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_byp(1, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
  endtask
  task automatic test_hold_output;
    out_ready = 1'b0;
    drive(1'b1, 96'hA, 3'b001, 3'b000, 3'b000, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0, 32'h0);
    tick;
    drive(1'b1, 96'hB, 3'b001, 3'b000, 3'b000, 5'd4, 5'd0, 5'd0, 32'h444, 32'h0, 32'h0);
    set_byp(0, 1'b1, 1'b0, 5'd4, 32'h999);
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL hold_in_ready[%0d] got %b want 0", c, in_ready); end
      vecs++; if (out_valid !== 1'b1 || ov0 !== 32'h44 || out_payload !== 96'hA)
        begin errs++; $display("FAIL hold_out[%0d] got v=%b val=%h pl=%h want v=1 val=44 pl=a", c, out_valid, ov0, out_payload); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL hold_release_in_ready got %b want 1", in_ready); end
    tick;
    vecs++; if (out_valid !== 1'b1 || out_payload !== 96'hB || ov0 !== 32'h999)
      begin errs++; $display("FAIL hold_next got v=%b pl=%h val=%h want v=1 pl=b val=999", out_valid, out_payload, ov0); end
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    set_byp(0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL hold_drained got %b want 0", out_valid); end
  endtask
  task automatic test_flush;
    drive(1'b1, 96'hC0, 3'b001, 3'b000, 3'b001, 5'd6, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick;
    drive(1'b1, 96'hC1, 3'b001, 3'b000, 3'b000, 5'd8, 5'd0, 5'd0, 32'h123, 32'h0, 32'h0);
    set_byp(0, 1'b1, 1'b0, 5'd6, 32'h77);
    flush = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick;
    flush = 1'b0;
    set_byp(0, 1'b0, 1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || out_payload !== 96'h0 || out_src_value !== 96'h0)
      begin errs++; $display("FAIL flush_cleared got v=%b pl=%h val=%h want all 0", out_valid, out_payload, out_src_value); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_after_in_ready got %b want 1", in_ready); end
    drive(1'b1, 96'hD, 3'b001, 3'b000, 3'b000, 5'd8, 5'd0, 5'd0, 32'h88, 32'h0, 32'h0);
    tick;
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    vecs++; if (out_valid !== 1'b1 || out_payload !== 96'hD || ov0 !== 32'h88)
      begin errs++; $display("FAIL flush_next got v=%b pl=%h val=%h want v=1 pl=d val=88", out_valid, out_payload, ov0); end
    tick;
  endtask
  task automatic test_rst_mid;
    out_ready = 1'b0;
    drive(1'b1, 96'hE, 3'b111, 3'b000, 3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    tick;
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    vecs++; if (out_valid !== 1'b1 || out_payload !== 96'hE) begin errs++; $display("FAIL rst_pre got v=%b pl=%h want v=1 pl=e", out_valid, out_payload); end
    rst = 1'b1;
    tick;
    vecs++; if (out_valid !== 1'b0 || out_payload !== 96'h0 || out_src_value !== 96'h0)
      begin errs++; $display("FAIL rst_mid got v=%b pl=%h val=%h want all 0", out_valid, out_payload, out_src_value); end
    rst = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    tick;
  endtask
  initial begin
    test_reset;
    test_no_hazard;
    test_bypass_wakeup;
    test_priority;
    test_hold_output;
    test_flush;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
